axis_matrix_loader: RTL

AXIS_MATRIX_LOADER -- requirements
Module: axis_matrix_loader

---
 rtl/alu_matrix_pkg.sv | 14 +
 rtl/axis_matrix_loader.sv | 117 +++++++++++
 2 files changed

// File: rtl/alu_matrix_pkg.sv
// Shared definitions for the ALU matrix datapath: default geometry and the
// loader FSM state encoding.
package alu_matrix_pkg;

    localparam int MATRIX_DIM_DEF = 4;
    localparam int DATA_W_DEF     = 8;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } ld_state_t;

endpackage

// File: rtl/axis_matrix_loader.sv
// Assembles an N*N matrix from an AXI-Stream of elements (row-major), holds it
// for the downstream core, and flags short/long frames with an irq and counter.
module axis_matrix_loader
    import alu_matrix_pkg::*;
#(
    parameter int MATRIX_DIM = MATRIX_DIM_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [DATA_W-1:0]                       s_axis_tdata,
    input  logic                                    s_axis_tvalid,
    output logic                                    s_axis_tready,
    input  logic                                    s_axis_tlast,
    output logic [MATRIX_DIM*MATRIX_DIM*DATA_W-1:0] mat_data,
    output logic                                    mat_valid,
    input  logic                                    mat_ready,
    output logic                                    err_irq,
    output logic [7:0]                              err_cnt
);

    localparam int ELEMS = MATRIX_DIM * MATRIX_DIM;
    localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

    ld_state_t        state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             err_irq_reg;
    logic [7:0]       err_cnt_reg;
    logic             accept;
    logic             wr_en;
    logic             err_evt;

    // Gated by rst_n so upstream sees no readiness while reset is held.
    assign s_axis_tready = rst_n && (state_reg != HOLD);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign mat_valid     = (state_reg == HOLD);
    assign err_irq       = err_irq_reg;
    assign err_cnt       = err_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= LOAD;
            idx_reg     <= '0;
            err_irq_reg <= 1'b0;
            err_cnt_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            err_irq_reg <= err_evt;
            if (err_evt && err_cnt_reg != 8'hFF)
                err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        wr_en      = 1'b0;
        err_evt    = 1'b0;
        case (state_reg)
            LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        idx_next = '0;
                        if (s_axis_tlast) begin
                            state_next = HOLD;
                        end else begin
                            state_next = DROP;
                            err_evt    = 1'b1;
                        end
                    end else if (s_axis_tlast) begin
                        idx_next = '0;
                        err_evt  = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (mat_ready) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end
            end
            DROP: begin
                // Overlong tail is swallowed silently up to its tlast.
                if (accept && s_axis_tlast) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = LOAD;
                idx_next   = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < ELEMS; gi++) begin : g_elem
            logic [DATA_W-1:0] elem_reg;

            always_ff @(posedge clk) begin
                if (!rst_n)
                    elem_reg <= '0;
                else if (wr_en && idx_reg == IDX_W'(gi))
                    elem_reg <= s_axis_tdata;
            end

            assign mat_data[gi*DATA_W +: DATA_W] = elem_reg;
        end
    endgenerate

endmodule
